// File: rtl/booth_mul_seq.sv
// Sequential 32x32 signed multiplier: radix-4 Booth, 16 iterations, 17-cycle latency.
// Define MUL_OVF_FLAG_EN to add the ovf32 output (product does not fit in signed 32 bits).
module booth_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
`ifdef MUL_OVF_FLAG_EN
  ,
  output logic        ovf32
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [33:0] acc_q, acc_d;
  logic [31:0] mq_q, mq_d;
  logic        q1_q, q1_d;
  logic [33:0] m_q, m_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] prod_q, prod_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // One Booth step on the current registers
  logic [2:0]  sel;
  logic [33:0] addend;
  logic        sub;
  logic [33:0] sum;
  logic [33:0] acc_n;
  logic [31:0] mq_n;
  logic        q1_n;

  always_comb begin
    sel = {mq_q[1:0], q1_q};
    addend = '0;
    sub = 1'b0;
    case (sel)
      3'b001, 3'b010: addend = m_q;
      3'b011:         addend = {m_q[32:0], 1'b0};
      3'b100: begin
        addend = {m_q[32:0], 1'b0};
        sub    = 1'b1;
      end
      3'b101, 3'b110: begin
        addend = m_q;
        sub    = 1'b1;
      end
      default:        addend = '0;
    endcase
    // Carry-out of the 34-bit add is deliberately dropped.
    sum = acc_q + (sub ? ~addend : addend) + {33'd0, sub};
    {acc_n, mq_n, q1_n} = {{2{sum[33]}}, sum, mq_q[31:1]};
  end

`ifdef MUL_OVF_FLAG_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
`ifdef MUL_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      CALC: begin
        acc_d = acc_n;
        mq_d  = mq_n;
        q1_d  = q1_n;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
          prod_d  = {acc_n[31:0], mq_n};
`ifdef MUL_OVF_FLAG_EN
          ovf_d   = !((&prod_d[63:31]) || (~|prod_d[63:31]));
`endif
        end
      end
      default: begin
        // IDLE and DONE both accept a new operation; DONE otherwise falls back to IDLE.
        if (start) begin
          state_d = CALC;
          acc_d   = '0;
          mq_d    = a;
          q1_d    = 1'b0;
          m_d     = {{2{b[31]}}, b};
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too, so an aborted operation leaves nothing behind.
      state_q <= IDLE;
      acc_q   <= '0;
      mq_q    <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef MUL_OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf32 = ovf_q;
`endif

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed table, corner sequences, and random
// operands checked against plain signed multiplication.
module tb_booth_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
`ifdef MUL_OVF_FLAG_EN
  logic        ovf32;
`endif

  int n_vec = 0;
  int n_err = 0;

  booth_mul_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
`ifdef MUL_OVF_FLAG_EN
    ,
    .ovf32   (ovf32)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Reference: the spec's meaning of the result, not its algorithm.
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return (p > 64'sd2147483647) || (p < -64'sd2147483648);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_ovf();
`ifdef MUL_OVF_FLAG_EN
    return ovf32;
`else
    return 1'b0;
`endif
  endfunction

  // Launch one operation from IDLE/DONE; lat = edges after the accepting edge until done is seen.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] p, output logic o, output int lat);
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
    p = product;
    o = get_ovf();
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) n++;
    end
  endtask

  vec_t        vecs[$];
  logic [63:0] p;
  logic        o;
  int          lat;
  int          nd;
  logic [31:0] ra, rb;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;

    vecs.push_back('{32'd10,        32'd15,        64'd150,                 1'b0});
    vecs.push_back('{32'hFFFFFFF9,  32'd3,         64'hFFFFFFFFFFFFFFEB,    1'b0});
    vecs.push_back('{32'h80000000,  32'h80000000,  64'h4000000000000000,    1'b1});
    vecs.push_back('{32'h7FFFFFFF,  32'h7FFFFFFF,  64'h3FFFFFFF00000001,    1'b1});
    vecs.push_back('{32'h80000000,  32'd1,         64'hFFFFFFFF80000000,    1'b0});
    vecs.push_back('{32'hFFFFFFFF,  32'h80000000,  64'h0000000080000000,    1'b1});
    vecs.push_back('{32'd0,         32'h12345678,  64'd0,                   1'b0});
    vecs.push_back('{32'hFFFFFFFF,  32'hFFFFFFFF,  64'd1,                   1'b0});
    vecs.push_back('{32'h00010000,  32'h00008000,  64'h0000000080000000,    1'b1});

    tick();
    tick();
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
`ifdef MUL_OVF_FLAG_EN
    check("reset_ovf", {63'd0, ovf32}, 64'd0);
`endif

    // start while reset is asserted must be ignored
    start = 1'b1;
    a = 32'd9;
    b = 32'd9;
    tick();
    start = 1'b0;
    check("start_in_reset_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("after_reset_busy", {63'd0, busy}, 64'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, p, o, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd16);
      check($sformatf("vec%0d_product", i), p, vecs[i].prod);
`ifdef MUL_OVF_FLAG_EN
      check($sformatf("vec%0d_ovf", i), {63'd0, o}, {63'd0, vecs[i].ovf});
`endif
      tick();
      check($sformatf("vec%0d_done_pulse", i), {63'd0, done}, 64'd0);
      check($sformatf("vec%0d_hold", i), product, vecs[i].prod);
    end

    // Back-to-back: start held high, operands swapped at the first done
    a = 32'd2;
    b = 32'd3;
    start = 1'b1;
    tick();
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
    check("b2b_first_latency", 64'(lat), 64'd16);
    check("b2b_first_product", product, 64'd6);
    a = 32'd4;
    b = 32'd5;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    check("b2b_done_spacing", 64'(lat), 64'd17);
    check("b2b_second_product", product, 64'd20);
    tick();
    tick();

    // start pulsed during CALC is ignored
    a = 32'd5;
    b = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    a = 32'd1;
    b = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int i = 5; i <= 40; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
    check("ignore_start_latency", 64'(lat), 64'd16);
    check("ignore_start_product", product, 64'd25);
    count_dones(25, nd);
    check("ignore_start_single_done", 64'(nd), 64'd0);

    // Reset during CALC at step 8 aborts the operation
    a = 32'd7;
    b = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("abort_busy_before", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_product", product, 64'd0);
    count_dones(25, nd);
    check("abort_no_done", 64'(nd), 64'd0);
    run_op(32'd3, 32'd4, p, o, lat);
    check("post_abort_latency", 64'(lat), 64'd16);
    check("post_abort_product", p, 64'd12);
    tick();

    // Random operands against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 1) ra = {ra[31], 31'd0};
      if (i % 8 == 2) rb = {32{rb[0]}};
      if (i % 8 == 3) ra = ra >>> 16;
      run_op(ra, rb, p, o, lat);
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'd16);
      check($sformatf("rand%0d_product a=%h b=%h", i, ra, rb), p, ref_prod(ra, rb));
`ifdef MUL_OVF_FLAG_EN
      check($sformatf("rand%0d_ovf", i), {63'd0, o}, {63'd0, ref_ovf(ra, rb)});
`endif
      if (i % 2 == 0) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
